lms_fifo_scheduler: RTL
=======================

// Module: lms_fifo_scheduler
// PURPOSE
//  Sequences the LMS sample FIFO: the 16-bit, 2048-word prefetch FIFO with a wr_en/wr_vld write port
//  and a rd_en/rd_vld read port. Accepts reference (x) and desired (d) audio samples from two sources.
//  Writes them into the FIFO as strictly interleaved x,d pairs. Tracks FIFO occupancy internally and
//  bursts whole frames of x/d pairs to the LMS filter engine, with first/last-of-frame markers.
// PARAMETERS
//  DATA_WIDTH   16   sample width; equals FIFO data width
//  DEPTH_WIDTH  11   FIFO address width; capacity CAP = 2**DEPTH_WIDTH words
//  FRAME_LEN    64   x/d pairs per frame; legal range 1 .. CAP/2
// PORTS
//  clk           in   1              single clock for the block and both FIFO ports
//  rst           in   1              synchronous, active-high reset
//  enable        in   1              allows new pairs to be admitted and new frames to start
//  x_data        in   DATA_WIDTH     reference sample
//  x_valid       in   1              x_data valid
//  x_ready       out  1              x sample accepted when x_valid & x_ready
//  d_data        in   DATA_WIDTH     desired sample
//  d_valid       in   1              d_data valid
//  d_ready       out  1              d sample accepted when d_valid & d_ready
//  fifo_wr_en    out  1              FIFO write strobe
//  fifo_wr_data  out  DATA_WIDTH     FIFO write data
//  fifo_wr_vld   in   1              FIFO can accept a write this cycle
//  fifo_rd_en    out  1              FIFO pop; rd_data is first-word-fall-through
//  fifo_rd_data  in   DATA_WIDTH     FIFO head word
//  fifo_rd_vld   in   1              fifo_rd_data valid
//  pair_x        out  DATA_WIDTH     x of the current output pair
//  pair_d        out  DATA_WIDTH     d of the current output pair
//  pair_valid    out  1              output pair valid
//  pair_ready    in   1              LMS engine accepts the pair
//  frame_first   out  1              qualifies pair_valid: pair 0 of a frame
//  frame_last    out  1              qualifies pair_valid: pair FRAME_LEN-1 of a frame
//  level         out  DEPTH_WIDTH+1  words held in FIFO per internal count (0..CAP)
//  frame_cnt     out  16             frames completed; wraps modulo 2**16
// BEHAVIOUR
//  Reset: every output is 0; write FSM = WR_X; read FSM = IDLE; level = 0; pair index = 0.
//    rst also resets the FIFO (shared at top level), so a reset mid-frame or mid-pair discards everything.
//  Write FSM (WR_X, WR_D):
//    WR_X: x_ready = enable & fifo_wr_vld & (level <= CAP-2). On x_valid&x_ready: fifo_wr_en=1,
//      fifo_wr_data=x_data, next state WR_D.
//    WR_D: d_ready = fifo_wr_vld, independent of enable, so no orphan x is ever left in the FIFO.
//      On d_valid&d_ready: write d_data, next state WR_X.
//    x_ready and d_ready are never high together. Both are combinational from state and inputs.
//  Level counter: +1 per write, -1 per pop, unchanged when both occur in the same cycle. Never exceeds CAP.
//  Read FSM (IDLE, RD_X, RD_D, OUT):
//    IDLE: when enable & level >= 2*FRAME_LEN, clear pair index and go to RD_X.
//    RD_X: when fifo_rd_vld, latch pair_x <= fifo_rd_data, assert fifo_rd_en this cycle, go to RD_D.
//    RD_D: same sequence, latching pair_d; go to OUT.
//    OUT: pair_valid=1. frame_first = (idx==0). frame_last = (idx==FRAME_LEN-1).
//      pair_x, pair_d and the flags hold stable until pair_ready.
//      On pair_ready: if last, frame_cnt++ and go to IDLE; else idx++ and go to RD_X.
//  Once committed, a frame always completes: dropping enable mid-frame stops admission and new frame starts only.
//  FIFO pops never starve mid-frame because the full frame was counted before the start.
//  fifo_rd_en is asserted only in RD_X/RD_D with fifo_rd_vld=1 (never pops an empty FIFO).
//  fifo_wr_en is asserted only with fifo_wr_vld=1.
//  Minimum pair period: 3 cycles (RD_X, RD_D, OUT) with pair_ready tied high.
//  FRAME_LEN=1: frame_first and frame_last are both high on every pair.
// TESTING
//  1 Reset, enable=1, feed 64 x/d pairs (x=i, d=0x8000+i) -> fifo writes alternate x,d.
//    level reaches 128, then one frame of 64 pairs out in order; first/last flags on pairs 0/63; frame_cnt=1.
//  2 Feed 63 pairs only -> no pair_valid, level=126. Feed 1 more pair -> frame starts within 2 cycles.
//  3 d_valid held low after an x accepted, enable dropped -> d_ready stays 1.
//    x_ready stays 0 until enable rises again; level odd (1) until d arrives.
//  4 Fill to level=2047, offer x -> x_ready=0. Fill to level=2046 -> x accepted, d accepted, level=2048.
//  5 pair_ready low for 10 cycles in OUT -> pair outputs stable, no fifo_rd_en.
//    Simultaneous write and pop cycle -> level unchanged.
//  6 Assert rst in the middle of frame pair 30 -> next cycle all outputs 0, level 0, both FSMs at reset state.

Source files
------------

// File: rtl/lms_fifo_scheduler.sv
// LMS sample FIFO sequencer: interleaves x/d samples into the prefetch FIFO and
// bursts whole frames of x/d pairs to the LMS engine once a frame's worth is buffered.
module lms_fifo_scheduler #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned DEPTH_WIDTH = 11,
    parameter int unsigned FRAME_LEN   = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [DATA_WIDTH-1:0]  x_data,
    input  logic                   x_valid,
    output logic                   x_ready,
    input  logic [DATA_WIDTH-1:0]  d_data,
    input  logic                   d_valid,
    output logic                   d_ready,
    output logic                   fifo_wr_en,
    output logic [DATA_WIDTH-1:0]  fifo_wr_data,
    input  logic                   fifo_wr_vld,
    output logic                   fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                   fifo_rd_vld,
    output logic [DATA_WIDTH-1:0]  pair_x,
    output logic [DATA_WIDTH-1:0]  pair_d,
    output logic                   pair_valid,
    input  logic                   pair_ready,
    output logic                   frame_first,
    output logic                   frame_last,
    output logic [DEPTH_WIDTH:0]   level,
    output logic [15:0]            frame_cnt
);

    localparam int unsigned LvlW = DEPTH_WIDTH + 1;
    localparam int unsigned Cap  = 2 ** DEPTH_WIDTH;
    localparam logic [LvlW-1:0]        XLevelMax  = LvlW'(Cap - 2);
    localparam logic [LvlW-1:0]        FrameWords = LvlW'(2 * FRAME_LEN);
    localparam logic [DEPTH_WIDTH-1:0] LastIdx    = DEPTH_WIDTH'(FRAME_LEN - 1);

    typedef enum logic {StWrX, StWrD} wr_state_e;
    typedef enum logic [1:0] {StIdle, StRdX, StRdD, StOut} rd_state_e;

    wr_state_e              wr_state_q;
    rd_state_e              rd_state_q;
    logic [LvlW-1:0]        level_q, level_d;
    logic [DEPTH_WIDTH-1:0] idx_q;
    logic [DATA_WIDTH-1:0]  pair_x_q, pair_d_q;
    logic                   pair_valid_q, frame_first_q, frame_last_q;
    logic [15:0]            frame_cnt_q;
    logic                   x_fire, d_fire;

    // x is only admitted with room for its d, so a pair never straddles a full FIFO.
    always_comb begin
        x_ready = !rst && (wr_state_q == StWrX) && enable && fifo_wr_vld
                  && (level_q <= XLevelMax);
        d_ready = !rst && (wr_state_q == StWrD) && fifo_wr_vld;
        x_fire  = x_valid && x_ready;
        d_fire  = d_valid && d_ready;
        fifo_wr_en   = x_fire || d_fire;
        fifo_wr_data = x_fire ? x_data : (d_fire ? d_data : '0);
        fifo_rd_en   = !rst && ((rd_state_q == StRdX) || (rd_state_q == StRdD)) && fifo_rd_vld;
    end

    always_comb begin
        level_d = level_q;
        unique case ({fifo_wr_en, fifo_rd_en})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q    <= StWrX;
            rd_state_q    <= StIdle;
            level_q       <= '0;
            idx_q         <= '0;
            pair_x_q      <= '0;
            pair_d_q      <= '0;
            pair_valid_q  <= 1'b0;
            frame_first_q <= 1'b0;
            frame_last_q  <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            if (x_fire) begin
                wr_state_q <= StWrD;
            end else if (d_fire) begin
                wr_state_q <= StWrX;
            end

            unique case (rd_state_q)
                StIdle: begin
                    if (enable && (level_q >= FrameWords)) begin
                        idx_q      <= '0;
                        rd_state_q <= StRdX;
                    end
                end
                StRdX: begin
                    if (fifo_rd_vld) begin
                        pair_x_q   <= fifo_rd_data;
                        rd_state_q <= StRdD;
                    end
                end
                StRdD: begin
                    if (fifo_rd_vld) begin
                        pair_d_q      <= fifo_rd_data;
                        pair_valid_q  <= 1'b1;
                        frame_first_q <= (idx_q == '0);
                        frame_last_q  <= (idx_q == LastIdx);
                        rd_state_q    <= StOut;
                    end
                end
                StOut: begin
                    if (pair_ready) begin
                        pair_valid_q  <= 1'b0;
                        frame_first_q <= 1'b0;
                        frame_last_q  <= 1'b0;
                        if (frame_last_q) begin
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                            rd_state_q  <= StIdle;
                        end else begin
                            idx_q      <= idx_q + 1'b1;
                            rd_state_q <= StRdX;
                        end
                    end
                end
                default: rd_state_q <= StIdle;
            endcase
        end
    end

    assign pair_x      = pair_x_q;
    assign pair_d      = pair_d_q;
    assign pair_valid  = pair_valid_q;
    assign frame_first = frame_first_q;
    assign frame_last  = frame_last_q;
    assign level       = level_q;
    assign frame_cnt   = frame_cnt_q;

endmodule
